// File: rtl/header_scan_if.sv
// Control and read-strobe bundle for header_scan. The scanner masters the
// read bus and is driven through the slave view by its environment.
interface header_scan_if;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic        ok_o;
  logic [1:0]  err_code_o;
  logic        rd_req_o;
  logic [2:0]  adr_o;
  logic        rd_ack_i;
  logic [31:0] dat_i;
  logic [31:0] drawing_o;
  logic [3:0]  version_o;
  logic [7:0]  revision_o;
  logic [19:0] build_date_o;

  modport master (
    input  start_i, rd_ack_i, dat_i,
    output busy_o, done_o, ok_o, err_code_o, rd_req_o, adr_o,
           drawing_o, version_o, revision_o, build_date_o
  );

  modport slave (
    output start_i, rd_ack_i, dat_i,
    input  busy_o, done_o, ok_o, err_code_o, rd_req_o, adr_o,
           drawing_o, version_o, revision_o, build_date_o
  );
endinterface

// File: rtl/header_scan.sv
// Reads the 8-byte header (drawing @0x0, version word @0x4), validates it and
// holds decoded identity plus status. HEADER_SCAN_RETRY_EN: one re-read per timeout.
module header_scan #(
  parameter logic [31:0] EXPECTED_DRAWING = 32'h08000101,
  parameter int unsigned TIMEOUT          = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  header_scan_if.master bus
);
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, REQ_DRW, WAIT_DRW, REQ_VER, WAIT_VER, FINISH} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        tmo, give_up, go_fin;
  logic [1:0]  fin_code;

  // Last allowed wait cycle with no ack; an ack on that cycle still wins.
  assign tmo = (cnt == 16'd1) && !bus.rd_ack_i;

`ifdef HEADER_SCAN_RETRY_EN
  logic retried;
  always_ff @(posedge clk_i) begin
    if (rst_i)
      retried <= 1'b0;
    else if (state == IDLE || (state == WAIT_DRW && bus.rd_ack_i))
      retried <= 1'b0;
    else if ((state == WAIT_DRW || state == WAIT_VER) && tmo)
      retried <= 1'b1;
  end
  assign give_up = tmo && retried;
`else
  assign give_up = tmo;
`endif

  always_comb begin
    state_nxt = state;
    go_fin    = 1'b0;
    fin_code  = 2'd0;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = REQ_DRW;
      REQ_DRW: state_nxt = WAIT_DRW;
      WAIT_DRW: begin
        if (bus.rd_ack_i) begin
          if (bus.dat_i == EXPECTED_DRAWING) state_nxt = REQ_VER;
          else begin state_nxt = FINISH; go_fin = 1'b1; fin_code = 2'd2; end
        end else if (give_up) begin
          state_nxt = FINISH; go_fin = 1'b1; fin_code = 2'd1;
        end else if (tmo) state_nxt = REQ_DRW;
      end
      REQ_VER: state_nxt = WAIT_VER;
      WAIT_VER: begin
        if (bus.rd_ack_i) begin
          state_nxt = FINISH;
          go_fin    = 1'b1;
          fin_code  = (bus.dat_i[3:0] == 4'd0) ? 2'd3 : 2'd0;
        end else if (give_up) begin
          state_nxt = FINISH; go_fin = 1'b1; fin_code = 2'd1;
        end else if (tmo) state_nxt = REQ_VER;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy_o   = (state != IDLE) && (state != FINISH);
  assign bus.done_o   = (state == FINISH);
  assign bus.rd_req_o = (state == REQ_DRW) || (state == REQ_VER);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      cnt              <= 16'd0;
      bus.ok_o         <= 1'b0;
      bus.err_code_o   <= 2'd0;
      bus.adr_o        <= 3'd0;
      bus.drawing_o    <= 32'd0;
      bus.version_o    <= 4'd0;
      bus.revision_o   <= 8'd0;
      bus.build_date_o <= 20'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.start_i) begin
          bus.ok_o         <= 1'b0;
          bus.err_code_o   <= 2'd0;
          bus.adr_o        <= 3'h0;
          bus.drawing_o    <= 32'd0;
          bus.version_o    <= 4'd0;
          bus.revision_o   <= 8'd0;
          bus.build_date_o <= 20'd0;
        end
        REQ_DRW, REQ_VER: cnt <= TMO;
        WAIT_DRW: begin
          if (bus.rd_ack_i) begin
            bus.drawing_o <= bus.dat_i;
            if (bus.dat_i == EXPECTED_DRAWING) bus.adr_o <= 3'h4;
          end else if (cnt != 16'd0) cnt <= cnt - 16'd1;
        end
        WAIT_VER: begin
          if (bus.rd_ack_i) begin
            bus.version_o    <= bus.dat_i[3:0];
            bus.revision_o   <= bus.dat_i[11:4];
            bus.build_date_o <= bus.dat_i[31:12];
          end else if (cnt != 16'd0) cnt <= cnt - 16'd1;
        end
        default: ;
      endcase
      if (go_fin) begin
        bus.err_code_o <= fin_code;
        bus.ok_o       <= (fin_code == 2'd0);
      end
    end
  end
endmodule
